// File: rtl/pixel_stream_engine.sv
// pixel_stream_engine: walks a padded BMP-style frame buffer, feeds pixels with hsync/vsync
// to the pipeline and writes the pipeline results back to the same addresses.
module pixel_stream_engine #(
  parameter int CHANNELS   = 3,
  parameter int CH_WIDTH   = 8,
  parameter int ADDR_WIDTH = 20,
  parameter int DIM_WIDTH  = 12,
  parameter int LATENCY    = 2,
  parameter int ROW_ALIGN  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         en,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [DIM_WIDTH-1:0]         width,
  input  logic [DIM_WIDTH-1:0]         height,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [CHANNELS*CH_WIDTH-1:0] rd_data,
  output logic                         pix_valid,
  output logic [CHANNELS*CH_WIDTH-1:0] pix_data,
  output logic                         hsync,
  output logic                         vsync,
  input  logic [CHANNELS*CH_WIDTH-1:0] dut_out,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [CHANNELS*CH_WIDTH-1:0] wr_data,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  frame_count
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, pix_addr, row_step, row_bytes, pad;
  logic [DIM_WIDTH-1:0] col, row, w_lat, h_lat;
  logic pv, hs, vs, zdone, go, last_col, last_px, pend;
  logic dl_v [LATENCY];
  logic [ADDR_WIDTH-1:0] dl_a [LATENCY];

  assign row_bytes = ADDR_WIDTH'(width) * ADDR_WIDTH'(CHANNELS);
  assign pad = (ADDR_WIDTH'(ROW_ALIGN) - (row_bytes & ADDR_WIDTH'(ROW_ALIGN - 1))) & ADDR_WIDTH'(ROW_ALIGN - 1);
  assign go = state == IDLE && start && width != '0 && height != '0;
  assign rd_en = state == STREAM && en;
  assign last_col = col == w_lat - DIM_WIDTH'(1);
  assign last_px = last_col && row == h_lat - DIM_WIDTH'(1);

  // The last delay stage drains this cycle, so only earlier stages keep the frame open.
  always_comb begin
    pend = pv;
    for (int i = 0; i < LATENCY - 1; i++) pend = pend | dl_v[i];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? STREAM : IDLE;
      STREAM:  state_nx = (rd_en && last_px) ? DRAIN : STREAM;
      DRAIN:   state_nx = pend ? DRAIN : FIN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
      pix_addr <= '0;
      row_step <= '0;
      col <= '0;
      row <= '0;
      w_lat <= '0;
      h_lat <= '0;
      pv <= 1'b0;
      hs <= 1'b0;
      vs <= 1'b0;
      zdone <= 1'b0;
      frame_count <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dl_v[i] <= 1'b0;
        dl_a[i] <= '0;
      end
    end else begin
      zdone <= state == IDLE && start && (width == '0 || height == '0);
      pv <= rd_en;
      hs <= rd_en && col == '0;
      vs <= rd_en && col == '0 && row == '0;
      pix_addr <= addr;
      dl_v[0] <= pv;
      dl_a[0] <= pix_addr;
      for (int i = 1; i < LATENCY; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_a[i] <= dl_a[i-1];
      end
      if (go) begin
        addr <= base_addr;
        col <= '0;
        row <= '0;
        w_lat <= width;
        h_lat <= height;
        row_step <= ADDR_WIDTH'(CHANNELS) + pad;
      end else if (rd_en) begin
        addr <= addr + (last_col ? row_step : ADDR_WIDTH'(CHANNELS));
        col <= last_col ? '0 : col + DIM_WIDTH'(1);
        row <= last_col ? row + DIM_WIDTH'(1) : row;
      end
      if (state == DRAIN && !pend) frame_count <= frame_count + 16'd1;
    end
  end

  assign rd_addr = addr;
  assign pix_valid = pv;
  assign pix_data = pv ? rd_data : '0;
  assign hsync = hs;
  assign vsync = vs;
  assign wr_en = dl_v[LATENCY-1];
  assign wr_addr = wr_en ? dl_a[LATENCY-1] : '0;
  assign wr_data = wr_en ? dut_out : '0;
  assign busy = state != IDLE;
  assign done = state == FIN || zdone;
endmodule

// File: doc/pixel_stream_engine.md
Name: pixel_stream_engine

Overview:
- Synthesizable, parametrised frame sequencer that replaces the bench-only BMP streaming loop.
- Walks a byte-addressed frame buffer row by row and skips BMP row padding.
- Assembles CHANNELS-byte pixels and presents them with hsync/vsync to the processing pipeline (`top`).
- Writes the pipeline's output pixels back to the same addresses after a fixed LATENCY.
- Honours `en` stalls and reports frame completion.

Parameters:
CHANNELS, 3, bytes per pixel (1..4)
CH_WIDTH, 8, bits per channel
ADDR_WIDTH, 20, byte address width
DIM_WIDTH, 12, width of runtime width/height inputs
LATENCY, 2, pipeline cycles from pix_data to matching dut_out (>=1)
ROW_ALIGN, 4, row byte alignment (power of two)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
en  in  1  stream enable; 0 stalls address generation
start  in  1  single-cycle pulse; begins a frame from IDLE
base_addr  in  ADDR_WIDTH  byte address of first pixel
width  in  DIM_WIDTH  pixels per row, sampled on start
height  in  DIM_WIDTH  rows per frame, sampled on start
rd_en  out  1  frame-buffer read strobe
rd_addr  out  ADDR_WIDTH  byte address of pixel LSB channel
rd_data  in  CHANNELS*CH_WIDTH  bytes [addr+CHANNELS-1 .. addr], valid 1 cycle after rd_en
pix_valid  out  1  pix_data valid
pix_data  out  CHANNELS*CH_WIDTH  pixel to pipeline
hsync  out  1  high with first pixel of each row
vsync  out  1  high with first pixel of frame
dut_out  in  CHANNELS*CH_WIDTH  pipeline result
wr_en  out  1  write strobe
wr_addr  out  ADDR_WIDTH  write byte address
wr_data  out  CHANNELS*CH_WIDTH  equals dut_out
busy  out  1  high outside IDLE
done  out  1  single-cycle pulse at frame end
frame_count  out  16  completed frames, wraps at 2^16

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; delay line cleared; frame_count 0. In-flight writes are discarded.
- Padding: pad = (ROW_ALIGN - (width*CHANNELS) mod ROW_ALIGN) mod ROW_ALIGN. Row stride = width*CHANNELS + pad. Computed on start.
- IDLE:
  - start=1 with width!=0 and height!=0: latch width, height, base_addr; go to STREAM next cycle.
  - start=1 with width==0 or height==0: done=1 next cycle; frame_count unchanged; stay in IDLE; no reads.
- STREAM, each cycle with en=1:
  - rd_en=1, rd_addr=current address; col advances.
  - At col==width-1: address += CHANNELS+pad, col=0, row advances.
  - Otherwise: address += CHANNELS.
  - After issuing pixel (height-1, width-1): go to DRAIN.
- STREAM with en=0: rd_en=0; address, row and col hold.
- Read return (cycle after rd_en): pix_valid=1, pix_data=rd_data.
  - hsync=1 when the pixel is at col 0; vsync=1 when it is at row 0, col 0.
  - Otherwise pix_valid, hsync, vsync are 0.
- Delay line (LATENCY stages) carries {valid, address} of each presented pixel and shifts every cycle regardless of en. A pixel presented at cycle t gives wr_en=1, wr_addr=its address, wr_data=dut_out at cycle t+LATENCY.
- DRAIN: wait until the delay line holds no valid entry. The cycle after the last wr_en: done=1, frame_count+1, state IDLE.
- start is ignored while busy=1. width/height changes mid-frame have no effect.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no overflow flag.
- busy=1 from the cycle after an accepted start through the done cycle; busy=0 after that.

Test Plan:
- CHANNELS=3, width=4, height=2, base 0, en=1 -> pad 0; rd_addr 0,3,6,9,12,15,18,21. hsync on pixels 0 and 4; vsync on pixel 0 only. done 1 cycle after last wr_en; frame_count=1.
- width=3, height=2 -> pad 3; rd_addr 0,3,6,12,15,18. Writes hit the same six addresses; bytes 9..11 are never written.
- en toggled 0 for 5 cycles mid-row 0 -> rd_addr holds with rd_en=0. Stream resumes at the next address with no gap or duplicate; the write sequence matches the uninterrupted run.
- LATENCY=2, dut_out = ~pix_data delayed 2 cycles -> every byte of the 4x2 frame reads back inverted after done.
- start with height=0 -> done pulse next cycle, zero rd_en, frame_count unchanged. Also: start asserted while busy -> ignored.
- reset_n low mid-DRAIN -> all outputs 0 immediately. Next start runs a clean frame from base_addr with vsync on the first pixel.
